spi_slave_rx: RTL
=================

Name: spi_slave_rx

Overview:
SPI slave receiver that sits directly downstream of the SPI master top. It takes the master's SCLK/MOSI/SS_n lines and oversamples them in the system clock domain. Each completed frame is assembled into a byte and buffered in a small first-word-fall-through FIFO for local consumers such as the display or register logic. Mode 0 only (CPOL=0, CPHA=0), MSB first.

Parameters:
DATA_W, 8, bits per SPI frame
FIFO_DEPTH, 4, receive FIFO entries; must be a power of 2, minimum 2
SYNC_STAGES, 2, flip-flops in each input synchronizer; minimum 2

Ports:
clock  input  1  system clock; must be at least 4x the SCLK frequency
reset  input  1  asynchronous, active-low reset (asserted when 0)
sclk  input  1  SPI clock from the master, asynchronous to clock
mosi  input  1  serial data from the master
ss_n  input  1  active-low slave select from the master
rd_en  input  1  pop request from the consumer
rd_data  output  DATA_W  head of the FIFO; valid while empty=0
empty  output  1  FIFO empty
full  output  1  FIFO full
busy  output  1  a frame is in progress (synced ss_n low and bit count nonzero)
overflow  output  1  sticky flag: a byte was dropped because the FIFO was full
ovf_clr  input  1  clears overflow
frame_err  output  1  one-cycle pulse when ss_n rises mid-byte

Behaviour:
- Reset values: rd_data=0, empty=1, full=0, busy=0, overflow=0, frame_err=0. Synchronizers, shift register, bit counter and FIFO pointers all clear.
- Input sync: sclk, mosi and ss_n each pass through SYNC_STAGES flops. SCLK rise and fall are detected from the last two sync stages, giving a one-cycle pulse per edge.
- FSM states:
  - IDLE: synced ss_n high. Go to SHIFT on ss_n falling; bit counter cleared.
  - SHIFT: on each SCLK rise, shift synced mosi into the LSB (MSB-first assembly) and increment the counter. When the count reaches DATA_W, go to PUSH.
  - PUSH: one cycle. Write the byte to the FIFO, clear the counter, return to SHIFT if ss_n is still low, otherwise IDLE.
- SCLK edges while ss_n is high are ignored.
- ss_n rising in SHIFT with count between 1 and DATA_W-1: discard the partial byte, pulse frame_err for 1 cycle, go to IDLE. With count 0, no error.
- Latency: empty falls SYNC_STAGES+2 clocks after the raw 8th SCLK rise (sync, edge detect, push).
- Consecutive frames with ss_n held low are supported back to back.
- FIFO behaviour:
  - First-word fall-through: rd_data always shows the head entry.
  - rd_en pops on the clock edge; rd_en while empty is ignored and leaves state unchanged.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. full when the pointers differ only in the MSB; empty when they are equal.
  - Push while full: byte dropped, overflow set; FIFO contents unchanged.
  - Push and pop in the same cycle while full: both execute, count unchanged, no overflow.
  - Push and pop in the same cycle while empty: the push executes, the pop is ignored.
- overflow: ovf_clr clears it. A simultaneous ovf_clr and new overflow event leaves it set (set wins).
- Reset asserted mid-frame: everything returns to reset values immediately; the partial byte is lost.

Optional Feature:
SPI_SLAVE_MISO_EN
- Defined: adds ports tx_byte (input, DATA_W) and miso (output, 1).
  - tx_byte is loaded into the TX shifter on ss_n falling and again on every PUSH.
  - miso drives the shifter MSB; the shifter moves left on each synced SCLK fall.
  - miso=0 while ss_n is high and during reset.
- Undefined: those ports and all TX logic are absent; receive behaviour is identical.

Decomposition:
- Package spi_pkg: DATA_W default constant, FSM state enum (IDLE, SHIFT, PUSH), pointer-width helper function.
- Sub-module spi_rx_fifo: parameterized FWFT FIFO with push, pop, full, empty and overflow-event output. Synchronizers and FSM stay in spi_slave_rx.

Test Plan:
- Single byte: ss_n low, 8 SCLK rises (100 ns period, clock 10 ns) with MOSI = 0100_1101 -> empty falls 4 clocks after the 8th rise, rd_data=8'h4D; rd_en pulse -> empty=1.
- Back-to-back frames: ss_n held low, bytes 8'hA5, 8'h3C -> FIFO holds A5 then 3C in order, frame_err never pulses.
- Aborted frame: ss_n rises after 5 bits -> frame_err pulses for exactly 1 clock, empty stays 1; next full byte 8'h81 is received correctly.
- Overflow: 5 bytes 8'h01..8'h05 sent with no reads -> full=1, overflow=1, reads return 01..04. ovf_clr -> overflow=0.
- Full-boundary simultaneity: FIFO full, rd_en asserted in the PUSH cycle of byte 8'hEE -> overflow stays 0, EE becomes the last entry.
- Mid-frame reset: reset=0 after 3 bits -> all outputs at reset values. After release, a byte 8'h7E is received cleanly. With SPI_SLAVE_MISO_EN and tx_byte=8'hC3, miso shifts out 1100_0011.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave receiver: default frame width,
// receive FSM state encoding and the FIFO pointer-width helper.
package spi_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PUSH  = 2'd2
    } rx_state_e;

    // Pointer carries one extra wrap bit so full and empty can be told apart
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// First-word-fall-through receive FIFO. The head entry is held in a
// register that is recomputed from next-state pointers, so rd_data, empty
// and full are all flop outputs. A push while full is dropped and reported
// on ovf_evt; a simultaneous pop frees the slot so the push goes through.
module spi_rx_fifo
    import spi_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic              ovf_evt
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [PW-1:0]     wr_ptr_s;
    logic [PW-1:0]     rd_ptr_s;
    logic [DATA_W-1:0] head_r;
    logic [DATA_W-1:0] head_s;
    logic              empty_r;
    logic              full_r;
    logic              empty_s;
    logic              full_s;
    logic              pop_do_s;
    logic              push_do_s;
    logic              ovf_evt_s;

    // Next-state pointers, flags and head entry
    always_comb begin
        pop_do_s  = pop & ~empty_r;
        push_do_s = push & (~full_r | pop_do_s);
        ovf_evt_s = push & full_r & ~pop_do_s;
        wr_ptr_s  = wr_ptr_r + {{AW{1'b0}}, push_do_s};
        rd_ptr_s  = rd_ptr_r + {{AW{1'b0}}, pop_do_s};
        empty_s   = (wr_ptr_s == rd_ptr_s);
        full_s    = (wr_ptr_s[AW-1:0] == rd_ptr_s[AW-1:0]) &&
                    (wr_ptr_s[AW] != rd_ptr_s[AW]);
        // A push landing on the slot that becomes the head bypasses memory
        if (push_do_s && (wr_ptr_r[AW-1:0] == rd_ptr_s[AW-1:0])) begin
            head_s = push_data;
        end else begin
            head_s = mem_r[rd_ptr_s[AW-1:0]];
        end
    end

    // Storage, pointers and registered status
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            head_r   <= {DATA_W{1'b0}};
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
        end else begin
            if (push_do_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= push_data;
            end
            wr_ptr_r <= wr_ptr_s;
            rd_ptr_r <= rd_ptr_s;
            head_r   <= head_s;
            empty_r  <= empty_s;
            full_r   <= full_s;
        end
    end

    assign rd_data = head_r;
    assign empty   = empty_r;
    assign full    = full_r;
    assign ovf_evt = ovf_evt_s;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver (MSB first). SCLK/MOSI/SS_n are oversampled in
// the system clock domain, frames are assembled by a small FSM and pushed
// into a FWFT FIFO. Optional transmit path enabled by SPI_SLAVE_MISO_EN
// adds tx_byte/miso.
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              ss_n,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic              busy,
    output logic              overflow,
    input  logic              ovf_clr,
    output logic              frame_err
`ifdef SPI_SLAVE_MISO_EN
    ,
    input  logic [DATA_W-1:0] tx_byte,
    output logic              miso
`endif
);

    localparam int CW = $clog2(DATA_W + 1);

    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic [SYNC_STAGES-1:0] ss_sync_r;
    logic                   sclk_prev_r;
    logic                   sclk_s;
    logic                   sclk_rise_s;
    logic                   mosi_s;
    logic                   ss_s;

    rx_state_e              state_r;
    logic [CW-1:0]          count_r;
    logic [DATA_W-1:0]      shift_r;
    logic                   busy_r;
    logic                   frame_err_r;
    logic                   overflow_r;
    logic                   push_s;
    logic                   ovf_evt_s;

    // Input synchronizers; ss_n chain resets to the deselected level
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sclk_sync_r <= {SYNC_STAGES{1'b0}};
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
            ss_sync_r   <= {SYNC_STAGES{1'b1}};
            sclk_prev_r <= 1'b0;
        end else begin
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
            ss_sync_r   <= {ss_sync_r[SYNC_STAGES-2:0], ss_n};
            sclk_prev_r <= sclk_sync_r[SYNC_STAGES-1];
        end
    end

    assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];
    assign ss_s        = ss_sync_r[SYNC_STAGES-1];
    assign sclk_rise_s = sclk_s & ~sclk_prev_r;

    // Receive FSM: frame start, bit assembly, push and abort detection
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            count_r     <= {CW{1'b0}};
            shift_r     <= {DATA_W{1'b0}};
            busy_r      <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    count_r <= {CW{1'b0}};
                    busy_r  <= 1'b0;
                    if (!ss_s) begin
                        state_r <= SHIFT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    if (ss_s) begin
                        // Deselect mid-byte discards the partial frame
                        if (count_r != {CW{1'b0}}) begin
                            frame_err_r <= 1'b1;
                        end else begin
                            frame_err_r <= 1'b0;
                        end
                        count_r <= {CW{1'b0}};
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else if (sclk_rise_s) begin
                        shift_r <= {shift_r[DATA_W-2:0], mosi_s};
                        count_r <= count_r + CW'(1'b1);
                        busy_r  <= 1'b1;
                        if (count_r == CW'(DATA_W - 1)) begin
                            state_r <= PUSH;
                        end else begin
                            state_r <= SHIFT;
                        end
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                PUSH: begin
                    count_r <= {CW{1'b0}};
                    busy_r  <= 1'b0;
                    if (ss_s) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                default: begin
                    count_r <= {CW{1'b0}};
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign push_s = (state_r == PUSH);

    spi_rx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_s),
        .push_data (shift_r),
        .pop       (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .ovf_evt   (ovf_evt_s)
    );

    // Sticky overflow; a new drop outranks a clear in the same cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow_r <= 1'b0;
        end else if (ovf_evt_s) begin
            overflow_r <= 1'b1;
        end else if (ovf_clr) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign busy      = busy_r;
    assign overflow  = overflow_r;
    assign frame_err = frame_err_r;

`ifdef SPI_SLAVE_MISO_EN
    logic              sclk_fall_s;
    logic [DATA_W-1:0] tx_shift_r;
    logic              miso_r;

    assign sclk_fall_s = ~sclk_s & sclk_prev_r;

    // Transmit shifter: reload at frame start and every push, advance on SCLK fall
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_shift_r <= {DATA_W{1'b0}};
            miso_r     <= 1'b0;
        end else if (ss_s) begin
            miso_r <= 1'b0;
        end else if ((state_r == IDLE) || (state_r == PUSH)) begin
            tx_shift_r <= tx_byte;
            miso_r     <= tx_byte[DATA_W-1];
        end else if (sclk_fall_s) begin
            tx_shift_r <= {tx_shift_r[DATA_W-2:0], 1'b0};
            miso_r     <= tx_shift_r[DATA_W-2];
        end else begin
            miso_r <= tx_shift_r[DATA_W-1];
        end
    end

    assign miso = miso_r;
`endif

endmodule
